// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO page layout,
// STATUS bit positions, register selector type and RAM index sizing.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [15:0] MMIO_PAGE = 16'hFFFF;

    // Word offsets (address[4:2]) of the peripheral registers
    localparam logic [2:0] REG_LED    = 3'd0;
    localparam logic [2:0] REG_SW     = 3'd1;
    localparam logic [2:0] REG_CYCLE  = 3'd2;
    localparam logic [2:0] REG_PERIOD = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_TIMER    = 0;
    localparam int ST_MISALIGN = 1;
    localparam int ST_UNMAPPED = 2;
    localparam int ST_BITS     = 3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CYCLE,
        SEL_PERIOD,
        SEL_STATUS
    } sel_e;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Periodic timer: PERIOD register, running count, registered event pulse.
// Ports: clock, reset_n, period_write/write_value in; period_value,
// timer_event (registered pulse), timer_hit (combinational expiry) out.
module mmio_timer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        period_write,
    input  logic [31:0] write_value,
    output logic [31:0] period_value,
    output logic        timer_event,
    output logic        timer_hit
);

    logic [31:0] count;

    // Expiry is decided on the current count; a zero period never expires
    assign timer_hit = (period_value != 32'd0)
                    && (count == period_value - 32'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_value <= 32'd0;
            count        <= 32'd0;
            timer_event  <= 1'b0;
        end else begin
            timer_event <= timer_hit;
            if (period_write) begin
                period_value <= write_value;
                count        <= 32'd0;
            end else if (period_value == 32'd0 || timer_hit) begin
                count <= 32'd0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory port responder: word RAM plus MMIO page (LED, SW, CYCLE,
// PERIOD, STATUS). Ports: clock, reset_n, memory_address/write_value/
// write_enable in, memory_read_value out, switches in, led_value and
// timer_event out.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int LED_WIDTH = 18,
    parameter int SW_WIDTH  = 18
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          memory_address,
    input  logic [31:0]          memory_write_value,
    input  logic                 memory_write_enable,
    output logic [31:0]          memory_read_value,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] led_value,
    output logic                 timer_event
);

    localparam int AW = idx_width(RAM_WORDS);

    logic [31:0]          ram [RAM_WORDS];
    logic [AW-1:0]        ram_idx;
    sel_e                 sel;
    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [31:0]          cycle_count;
    logic [ST_BITS-1:0]   status;
    logic [ST_BITS-1:0]   status_set;
    logic [ST_BITS-1:0]   status_clr;
    logic [31:0]          period_value;
    logic                 timer_hit;
    logic                 wr_ram;
    logic                 wr_led;
    logic                 wr_cycle;
    logic                 wr_period;
    logic                 wr_status;

    assign ram_idx = memory_address[AW+1:2];

    // Byte lanes are ignored: decode works on the word address only
    always_comb begin
        sel = SEL_NONE;
        if (memory_address[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else if (memory_address[31:16] == MMIO_PAGE
                     && memory_address[15:5] == '0) begin
            case (memory_address[4:2])
                REG_LED:    sel = SEL_LED;
                REG_SW:     sel = SEL_SW;
                REG_CYCLE:  sel = SEL_CYCLE;
                REG_PERIOD: sel = SEL_PERIOD;
                REG_STATUS: sel = SEL_STATUS;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    assign wr_ram    = memory_write_enable && (sel == SEL_RAM);
    assign wr_led    = memory_write_enable && (sel == SEL_LED);
    assign wr_cycle  = memory_write_enable && (sel == SEL_CYCLE);
    assign wr_period = memory_write_enable && (sel == SEL_PERIOD);
    assign wr_status = memory_write_enable && (sel == SEL_STATUS);

    // Async-read array with no reset so it maps onto distributed RAM
    always_ff @(posedge clock) begin
        if (wr_ram) begin
            ram[ram_idx] <= memory_write_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_value   <= '0;
            sw_meta     <= '0;
            sw_sync     <= '0;
            cycle_count <= 32'd0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (wr_led) begin
                led_value <= memory_write_value[LED_WIDTH-1:0];
            end
            cycle_count <= wr_cycle ? 32'd0 : cycle_count + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .period_write (wr_period),
        .write_value  (memory_write_value),
        .period_value (period_value),
        .timer_event  (timer_event),
        .timer_hit    (timer_hit)
    );

    always_comb begin
        status_set              = '0;
        status_set[ST_TIMER]    = timer_hit;
        status_set[ST_MISALIGN] = memory_write_enable
                                  && (memory_address[1:0] != 2'b00);
        status_set[ST_UNMAPPED] = memory_write_enable && (sel == SEL_NONE);
        status_clr              = wr_status
                                  ? memory_write_value[ST_BITS-1:0] : '0;
    end

    // A hardware set wins over a same-cycle write-1-to-clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status <= '0;
        end else begin
            status <= (status & ~status_clr) | status_set;
        end
    end

    always_comb begin
        memory_read_value = 32'd0;
        case (sel)
            SEL_RAM:    memory_read_value = ram[ram_idx];
            SEL_LED:    memory_read_value = {{(32-LED_WIDTH){1'b0}}, led_value};
            SEL_SW:     memory_read_value = {{(32-SW_WIDTH){1'b0}}, sw_sync};
            SEL_CYCLE:  memory_read_value = cycle_count;
            SEL_PERIOD: memory_read_value = period_value;
            SEL_STATUS: memory_read_value = {{(32-ST_BITS){1'b0}}, status};
            default:    memory_read_value = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder: directed stimulus, spec-level
// reference model checked every negedge, plus literal expectations.
module tb_data_memory_responder;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_SW     = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
    localparam logic [31:0] A_PERIOD = 32'hFFFF_000C;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0010;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] memory_address = 32'd0;
    logic [31:0] memory_write_value = 32'd0;
    logic        memory_write_enable = 1'b0;
    logic [31:0] memory_read_value;
    logic [17:0] switches = 18'd0;
    logic [17:0] led_value;
    logic        timer_event;

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_responder dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .memory_address      (memory_address),
        .memory_write_value  (memory_write_value),
        .memory_write_enable (memory_write_enable),
        .memory_read_value   (memory_read_value),
        .switches            (switches),
        .led_value           (led_value),
        .timer_event         (timer_event)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0] m_ram [1024];
    bit          m_ok  [1024];
    logic [17:0] m_led = 0;
    logic [17:0] m_sw1 = 0;
    logic [17:0] m_sw2 = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_per = 0;
    int unsigned m_since = 0;
    logic [2:0]  m_status = 0;
    logic        m_evt = 0;

    function automatic bit m_mapped(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (a >> 2) < 1024 || w == A_LED || w == A_SW
            || w == A_CYCLE || w == A_PERIOD || w == A_STATUS;
    endfunction

    // Edge k after a PERIOD write expires when k is a multiple of PERIOD
    function automatic bit m_hit();
        return m_per != 0 && ((m_since + 1) % m_per) == 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_led <= 0; m_sw1 <= 0; m_sw2 <= 0; m_cyc <= 0;
            m_per <= 0; m_since <= 0; m_status <= 0; m_evt <= 0;
        end else begin
            logic [31:0] w;
            logic [2:0]  setb;
            logic [2:0]  clrb;
            w = memory_address & 32'hFFFF_FFFC;
            setb = {memory_write_enable && !m_mapped(memory_address),
                    memory_write_enable && memory_address[1:0] != 0,
                    m_hit()};
            clrb = (memory_write_enable && w == A_STATUS)
                   ? memory_write_value[2:0] : 3'b000;
            m_status <= (m_status & ~clrb) | setb;
            m_evt <= m_hit();
            m_sw1 <= switches;
            m_sw2 <= m_sw1;
            m_cyc <= (memory_write_enable && w == A_CYCLE) ? 0 : m_cyc + 1;
            if (memory_write_enable && w == A_PERIOD) begin
                m_per <= memory_write_value;
                m_since <= 0;
            end else begin
                m_since <= m_since + 1;
            end
            if (memory_write_enable && w == A_LED)
                m_led <= memory_write_value[17:0];
            if (memory_write_enable && (memory_address >> 2) < 1024) begin
                m_ram[memory_address[11:2]] <= memory_write_value;
                m_ok[memory_address[11:2]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [31:0] w;
        w = memory_address & 32'hFFFF_FFFC;
        chk("m_led", {14'd0, led_value}, {14'd0, m_led});
        chk("m_evt", {31'd0, timer_event}, {31'd0, m_evt});
        if ((memory_address >> 2) < 1024) begin
            if (m_ok[memory_address[11:2]])
                chk("m_ram", memory_read_value, m_ram[memory_address[11:2]]);
        end else if (w == A_LED) chk("m_rd_led", memory_read_value, {14'd0, m_led});
        else if (w == A_SW) chk("m_rd_sw", memory_read_value, {14'd0, m_sw2});
        else if (w == A_CYCLE) chk("m_rd_cyc", memory_read_value, m_cyc);
        else if (w == A_PERIOD) chk("m_rd_per", memory_read_value, m_per);
        else if (w == A_STATUS) chk("m_rd_st", memory_read_value, {29'd0, m_status});
        else chk("m_rd_unm", memory_read_value, 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] v,
                         input logic we);
        @(posedge clock);
        #1;
        memory_address = a;
        memory_write_value = v;
        memory_write_enable = we;
        #1;
    endtask

    initial begin
        drive(A_CYCLE, 32'd0, 1'b0);
        chk("rst_cycle", memory_read_value, 32'd0);
        chk("rst_led", {14'd0, led_value}, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("rst_status", memory_read_value, 32'd0);
        reset_n = 1'b1;

        // 1: same-cycle read returns old data
        drive(32'h10, 32'h1111_1111, 1'b1);
        drive(32'h14, 32'h2222_2222, 1'b1);
        drive(32'h10, 32'hDEAD_BEEF, 1'b1);
        chk("ram_old", memory_read_value, 32'h1111_1111);
        drive(32'h10, 32'd0, 1'b0);
        chk("ram_new", memory_read_value, 32'hDEAD_BEEF);
        drive(32'h14, 32'd0, 1'b0);
        chk("ram_neighbour", memory_read_value, 32'h2222_2222);

        // 2: LED
        drive(A_LED, 32'h0003_FFFF, 1'b1);
        drive(A_LED, 32'd0, 1'b0);
        chk("led_out", {14'd0, led_value}, 32'h0003_FFFF);
        chk("led_read", memory_read_value, 32'h0003_FFFF);

        // 3: timer with PERIOD=3, W1C during and outside a hit
        drive(A_PERIOD, 32'd3, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt1", {31'd0, timer_event}, 32'd0);
        chk("t_st0", memory_read_value, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt3", {31'd0, timer_event}, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt4", {31'd0, timer_event}, 32'd1);
        chk("t_st_hit", memory_read_value, 32'd1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt5", {31'd0, timer_event}, 32'd0);
        drive(A_STATUS, 32'd1, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt7", {31'd0, timer_event}, 32'd1);
        chk("w1c_vs_hit", memory_read_value, 32'd1);
        drive(A_STATUS, 32'd1, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("w1c_clear", memory_read_value, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("t_evt10", {31'd0, timer_event}, 32'd1);
        drive(A_PERIOD, 32'd0, 1'b1);
        drive(A_STATUS, 32'd7, 1'b1);

        // 4: misaligned and unmapped stores
        drive(32'h13, 32'hCAFE_F00D, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("st_misalign", memory_read_value, 32'd2);
        drive(32'h10, 32'd0, 1'b0);
        chk("ram_misalign", memory_read_value, 32'hCAFE_F00D);
        drive(A_STATUS, 32'd2, 1'b1);
        drive(32'h0, 32'hAAAA_5555, 1'b1);
        drive(32'h8000_0000, 32'h1234_5678, 1'b1);
        chk("unm_read", memory_read_value, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("st_unmapped", memory_read_value, 32'd4);
        drive(32'h0, 32'd0, 1'b0);
        chk("ram_unm_keep", memory_read_value, 32'hAAAA_5555);
        drive(A_SW, 32'h3_FFFF, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("ro_store", memory_read_value, 32'd4);

        // 5: switch sync latency and CYCLE clear
        drive(A_SW, 32'd0, 1'b0);
        switches = 18'h155;
        #1 chk("sw_lat0", memory_read_value, 32'd0);
        drive(A_SW, 32'd0, 1'b0);
        chk("sw_lat1", memory_read_value, 32'd0);
        drive(A_SW, 32'd0, 1'b0);
        chk("sw_lat2", memory_read_value, 32'h155);
        drive(A_CYCLE, 32'h55, 1'b1);
        drive(A_CYCLE, 32'd0, 1'b0);
        chk("cyc_clr", memory_read_value, 32'd0);
        drive(A_CYCLE, 32'd0, 1'b0);
        chk("cyc_inc", memory_read_value, 32'd1);

        // 6: reset in the middle of a timer period
        drive(A_PERIOD, 32'd5, 1'b1);
        for (int i = 0; i < 4; i++) drive(A_PERIOD, 32'd0, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_per", memory_read_value, 32'd0);
        chk("rst_led2", {14'd0, led_value}, 32'd0);
        chk("rst_evt", {31'd0, timer_event}, 32'd0);
        drive(A_CYCLE, 32'd0, 1'b0);
        chk("rst_cyc2", memory_read_value, 32'd0);
        drive(A_STATUS, 32'd0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(A_STATUS, 32'd0, 1'b0);
            chk("no_evt", {31'd0, timer_event}, 32'd0);
        end
        drive(A_PERIOD, 32'd1, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("p1_evt", {31'd0, timer_event}, 32'd1);
        drive(A_STATUS, 32'd0, 1'b0);
        chk("p1_evt2", {31'd0, timer_event}, 32'd1);

        @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
